serial_shift_unit: RTL and testbench
====================================

// Module: serial_shift_unit
// PURPOSE
//  Multi-cycle shifter for the datapath's shift instructions (sll/srl/sra, and rotate).
//  Consumes the 32-bit zero-extended shift amount: either the extended shamt field or an rs value for variable shifts.
//  Reduces that amount to a 5-bit count. Shifts the operand one bit per clock.
//  Reports completion with a start/busy/done handshake to the control unit.
// PARAMETERS
//  WIDTH  32  operand / result width in bits
//  SHW    5   shift-count width; must equal log2(WIDTH)
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  op         in   2      00 sll, 01 srl, 10 sra, 11 ror (rotate right)
//  data_in    in   WIDTH  operand to shift; captured on accepted start
//  amt_in     in   WIDTH  extended shift amount; only amt_in[SHW-1:0] is used
//  shamt_out  out  SHW    registered copy of the captured count (amt_in[4:0])
//  busy       out  1      high in SHIFT state
//  done       out  1      one-cycle pulse; result valid
//  result     out  WIDTH  shifted value; held stable from done until the next accepted start
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE.
//   - busy=0, done=0, result=0, shamt_out=0, internal count=0, op register=00.
//  States: IDLE, SHIFT, DONE.
//  Start acceptance:
//   - IDLE & start at edge E: capture data_in->work reg, amt_in[4:0]->count and shamt_out, op->op reg.
//   - amt_in[31:5] are ignored: no saturation, no error. The count is amt mod 32.
//   - count==0 -> next state DONE; else -> SHIFT.
//  SHIFT: each edge applies one 1-bit step to the work reg and decrements count.
//   - sll: {w[30:0],0}
//   - srl: {0,w[31:1]}
//   - sra: {w[31],w[31:1]}
//   - ror: {w[0],w[31:1]}
//   - When the step that makes count 0 occurs -> DONE.
//  DONE: done=1 for exactly one cycle, result=work reg. Next edge -> IDLE.
//  Latency: for count N, done is high in the cycle after edge E+max(N,1).
//   - N=0: done in cycle after E+1.
//   - N=31: done in cycle after E+31.
//  Ordering: busy and done are never high together. busy=1 from E+1 until the DONE state is entered.
//  result holds its value through IDLE. It updates only on entry to DONE.
//  start is ignored in SHIFT and DONE: no queuing, no restart. Inputs change freely while busy.
//  Reset asserted mid-SHIFT: immediate return to reset values. The partial result is discarded.
//  Count arithmetic is unsigned SHW-bit. It never wraps below 0, because the exit is taken at 0.
//  No combinational path from any input to any output.
// TESTING
//  1. sll, data_in=0x00000001, amt_in=4 -> busy 4 cycles, done pulse, result=0x00000010, shamt_out=4.
//  2. sra, data_in=0x80000000, amt_in=31 -> done after 31 shift cycles, result=0xFFFFFFFF.
//     Repeat with srl -> result=0x00000001.
//  3. ror, data_in=0x0000000F, amt_in=0xFFFFFFE4 -> shamt_out=4, result=0xF0000000 (upper amt bits ignored).
//  4. sll, data_in=0x12345678, amt_in=0 -> busy never asserts, done in cycle after E+1, result=0x12345678.
//  5. start re-pulsed with new data while busy (amt_in=8) -> ignored, first result unchanged.
//     Then rst=1 mid-SHIFT -> busy=0, done=0, result=0 asynchronously. A fresh start after reset works normally.

Source files
------------

// File: rtl/serial_shift_unit.sv
// serial_shift_unit
//   Multi-cycle shifter for sll/srl/sra/ror. The operand is shifted one bit
//   per clock. The count is the low SHW bits of the extended shift amount.
//   Ports:
//     clk, rst      - clock, asynchronous active-high reset
//     start         - request, sampled only while idle
//     op            - 00 sll, 01 srl, 10 sra, 11 ror
//     data_in       - operand, captured on an accepted start
//     amt_in        - extended shift amount; only amt_in[SHW-1:0] is used
//     shamt_out     - registered copy of the captured count
//     busy          - high while shifting
//     done          - one-cycle pulse when result becomes valid
//     result        - shifted value, held until the next completion
module serial_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] amt_in,
  output logic [SHW-1:0]   shamt_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_ZERO = '0;
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] step;

  // Upper amount bits carry no meaning here: the count is amt mod 2**SHW.
  logic unused_amt;
  assign unused_amt = ^amt_in[WIDTH-1:SHW];

  always_comb begin
    step = work;
    case (op_r)
      2'b00:   step = {work[WIDTH-2:0], 1'b0};
      2'b01:   step = {1'b0, work[WIDTH-1:1]};
      2'b10:   step = {work[WIDTH-1], work[WIDTH-1:1]};
      default: step = {work[0], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      op_r      <= 2'b00;
      shamt_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work      <= data_in;
            count     <= amt_in[SHW-1:0];
            shamt_out <= amt_in[SHW-1:0];
            op_r      <= op;
            if (amt_in[SHW-1:0] == CNT_ZERO) begin
              // Zero count: DONE is entered with done low and the pulse is
              // raised one edge later, giving the minimum latency of one.
              state <= DONE;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          work  <= step;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= step;
          end
        end
        DONE: begin
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done   <= 1'b1;
            result <= work;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
module tb_serial_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [31:0] amt_in;
  logic [4:0]  shamt_out;
  logic        busy;
  logic        done;
  logic [31:0] result;

  serial_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .data_in   (data_in),
    .amt_in    (amt_in),
    .shamt_out (shamt_out),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  sh;
    int          ecyc;
    int          lat;
    int          n;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   sim_end = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, expv);
    end
  endtask

  // Drive one request; the expected response goes to the scoreboard.
  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [31:0] a,
                       input logic [31:0] expr, input int n);
    exp_t e;
    @(negedge clk);
    op = o; data_in = d; amt_in = a; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e.res  = expr;
    e.sh   = a[4:0];
    e.ecyc = cyc;
    e.lat  = (n == 0) ? 1 : n;
    e.n    = n;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout pending=%0d required=0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    int   busy_cnt;
    exp_t e;
    busy_cnt = 0;
    while (!sim_end) begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          chk("busy_done_excl", {31'd0, busy}, 32'd0);
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done actual=1 required=0");
          end else begin
            e = q.pop_front();
            chk("result", result, e.res);
            chk("shamt_out", {27'd0, shamt_out}, {27'd0, e.sh});
            chk("latency", 32'(cyc - e.ecyc), 32'(e.lat));
            chk("busy_cycles", 32'(busy_cnt), 32'(e.n));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; data_in = '0; amt_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_shamt", {27'd0, shamt_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 4);       wait_idle();
    issue(2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31);     wait_idle();
    issue(2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 31);     wait_idle();
    issue(2'b11, 32'h0000_000F, 32'hFFFF_FFE4, 32'hF000_0000, 4); wait_idle();
    issue(2'b00, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);       wait_idle();
    issue(2'b01, 32'hF000_0000, 32'h0000_0021, 32'h7800_0000, 1); wait_idle();
    issue(2'b10, 32'h8000_0010, 32'd4, 32'hF800_0001, 4);       wait_idle();
    issue(2'b11, 32'h1234_5678, 32'd8, 32'h7812_3456, 8);       wait_idle();
    issue(2'b00, 32'hFFFF_FFFF, 32'd31, 32'h8000_0000, 31);     wait_idle();

    // Restart attempt while shifting must be ignored.
    issue(2'b00, 32'h0000_0001, 32'd8, 32'h0000_0100, 8);
    repeat (2) @(negedge clk);
    op = 2'b11; data_in = 32'h0000_FFFF; amt_in = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result", result, 32'h0000_0100);
    chk("hold_shamt", {27'd0, shamt_out}, 32'd8);

    // Asynchronous reset in the middle of a shift.
    issue(2'b01, 32'hFFFF_FFFF, 32'd20, 32'h0000_0FFF, 20);
    repeat (5) @(posedge clk);
    #1 chk("busy_mid", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_shamt", {27'd0, shamt_out}, 32'd0);
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(2'b11, 32'h0000_0001, 32'd1, 32'h8000_0000, 1);       wait_idle();

    sim_end = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
